key_command: RTL and testbench

Input conditioning stage directly upstream of the rocket movement controller. It converts the raw active-low board push-buttons into clean commands: `start` (one-cycle pulse), and `left`/`right` move requests held until the movement datapath acknowledges completion. Each input is synchronised and debounced. Holding a direction key auto-repeats the request at a fixed rate, so the rocket glides while the key stays down.

---
 rtl/key_command.sv | 142 ++++++++++++++
 tb/tb_key_command.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/key_command.sv
// key_command: synchronises and debounces the active-low board keys, then
// turns them into a start pulse and handshaked, auto-repeating move requests.
module key_command #(
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd50_000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd10_000_000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd2_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_left_n,
    input  logic key_right_n,
    input  logic key_start_n,
    input  logic moveDone,
    output logic left,
    output logic right,
    output logic start
);

    typedef enum logic [1:0] {IDLE, REQ, ACKLOW, HOLD} state_t;

    // Key index: 0 = left, 1 = right, 2 = start.
    logic [2:0]  sync1_q, sync1_d;
    logic [2:0]  sync2_q, sync2_d;
    logic [2:0]  db_q, db_d;
    logic [2:0]  level;
    logic [23:0] cnt_q [3];
    logic [23:0] cnt_d [3];

    logic        start_prev_q, start_prev_d;
    logic        start_q, start_d;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic        first_q, first_d;
    logic        left_q, left_d;
    logic        right_q, right_d;
    logic [23:0] rep_q, rep_d;
    logic        held;

    always_comb begin
        sync1_d = {key_start_n, key_right_n, key_left_n};
        sync2_d = sync1_q;
        level   = ~sync2_q;
        db_d    = db_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (level[i] != db_q[i]) begin
                if (cnt_q[i] == DEBOUNCE_CYCLES - 24'd1) begin
                    db_d[i] = level[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 24'd1;
                end
            end
        end
        start_prev_d = db_q[2];
        start_d      = db_q[2] & ~start_prev_q;
    end

    // dir_q: 0 = left, 1 = right
    assign held = dir_q ? db_q[1] : db_q[0];

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        first_d = first_q;
        left_d  = left_q;
        right_d = right_q;
        rep_d   = rep_q;
        unique case (state_q)
            IDLE: begin
                if (db_q[0] ^ db_q[1]) begin
                    state_d = REQ;
                    dir_d   = db_q[1];
                    first_d = 1'b1;
                    left_d  = db_q[0];
                    right_d = db_q[1];
                end
            end
            REQ: begin
                if (moveDone) begin
                    state_d = ACKLOW;
                    left_d  = 1'b0;
                    right_d = 1'b0;
                end
            end
            ACKLOW: begin
                if (!moveDone) begin
                    state_d = HOLD;
                    rep_d   = first_q ? REPEAT_DELAY : REPEAT_PERIOD;
                    first_d = 1'b0;
                end
            end
            HOLD: begin
                if (!held) begin
                    state_d = IDLE;
                end else if (rep_q == 24'd1) begin
                    state_d = REQ;
                    left_d  = ~dir_q;
                    right_d = dir_q;
                end else begin
                    rep_d = rep_q - 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            db_q         <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            start_prev_q <= 1'b0;
            start_q      <= 1'b0;
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            first_q      <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            rep_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            start_prev_q <= start_prev_d;
            start_q      <= start_d;
            state_q      <= state_d;
            dir_q        <= dir_d;
            first_q      <= first_d;
            left_q       <= left_d;
            right_q      <= right_d;
            rep_q        <= rep_d;
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign start = start_q;

endmodule

// File: tb/tb_key_command.sv
// Scoreboard bench for key_command: stimulus queues expected output edges
// with their cycle numbers, a negedge monitor pops and compares them.
module tb_key_command;

    localparam int START_R = 0;
    localparam int START_F = 1;
    localparam int L_R     = 2;
    localparam int L_F     = 3;
    localparam int R_R     = 4;
    localparam int R_F     = 5;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t  exp_q[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_left_n = 1'b1;
    logic key_right_n = 1'b1;
    logic key_start_n = 1'b1;
    logic moveDone = 1'b0;
    logic left, right, start;

    int   cyc = 0;
    int   chk = 0;
    int   err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_command #(
        .DEBOUNCE_CYCLES(24'd4),
        .REPEAT_DELAY   (24'd20),
        .REPEAT_PERIOD  (24'd8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_left_n (key_left_n),
        .key_right_n(key_right_n),
        .key_start_n(key_start_n),
        .moveDone   (moveDone),
        .left       (left),
        .right      (right),
        .start      (start)
    );

    function automatic void expect_ev(int k, int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    task automatic got(int k);
        ev_t e;
        chk++;
        if (exp_q.size() == 0) begin
            err++;
            $display("FAIL event: got kind=%0d at cyc=%0d, required none",
                     k, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                err++;
                $display("FAIL event: got kind=%0d cyc=%0d, required kind=%0d cyc=%0d",
                         k, cyc, e.kind, e.cyc);
            end
        end
    endtask

    // Monitor: every output edge must match the head of the queue.
    logic pl = 1'b0, pr = 1'b0, ps = 1'b0;
    always @(negedge clk) begin
        if (start && !ps) got(START_R);
        if (!start && ps) got(START_F);
        if (left && !pl)  got(L_R);
        if (!left && pl)  got(L_F);
        if (right && !pr) got(R_R);
        if (!right && pr) got(R_F);
        ps = start;
        pl = left;
        pr = right;
    end

    task automatic check_bit(string name, logic act, logic req);
        chk++;
        if (act !== req) begin
            err++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic drain(string name);
        chk++;
        if (exp_q.size() != 0) begin
            err++;
            $display("FAIL %s: %0d events missing, first kind=%0d cyc=%0d",
                     name, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic step_to(int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t0;
        int r;
        bit first;

        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_left", left, 1'b0);
        check_bit("reset_right", right, 1'b0);
        check_bit("reset_start", start, 1'b0);
        reset = 1'b0;
        step_to(cyc + 5);

        // Start key with two 2-cycle bounces ahead of the real press.
        t0 = cyc;
        key_start_n = 1'b0; step_to(t0 + 2);
        key_start_n = 1'b1; step_to(t0 + 4);
        key_start_n = 1'b0; step_to(t0 + 6);
        key_start_n = 1'b1; step_to(t0 + 8);
        expect_ev(START_R, t0 + 15);
        expect_ev(START_F, t0 + 16);
        key_start_n = 1'b0; step_to(t0 + 18);
        key_start_n = 1'b1; step_to(t0 + 35);
        drain("start_key");

        // Single left press, acknowledged once, released before repeat.
        t0 = cyc;
        expect_ev(L_R, t0 + 7);
        expect_ev(L_F, t0 + 13);
        key_left_n = 1'b0; step_to(t0 + 12);
        moveDone = 1'b1;   step_to(t0 + 15);
        moveDone = 1'b0;
        key_left_n = 1'b1; step_to(t0 + 50);
        drain("single_left");
        check_bit("single_left_right_low", right, 1'b0);

        // Right held: first repeat 21 after ack fall, then every 9.
        t0 = cyc;
        key_right_n = 1'b0;
        r = t0 + 7;
        first = 1'b1;
        while (r < t0 + 190) begin
            expect_ev(R_R, r);
            expect_ev(R_F, r + 4);
            step_to(r + 3);
            moveDone = 1'b1;
            step_to(r + 4);
            moveDone = 1'b0;
            r = r + (first ? 25 : 13);
            first = 1'b0;
        end
        step_to(t0 + 193);
        key_right_n = 1'b1;
        step_to(t0 + 225);
        drain("auto_repeat");

        // Both keys together: nothing until left lets go.
        t0 = cyc;
        key_left_n = 1'b0;
        key_right_n = 1'b0;
        step_to(t0 + 10);
        check_bit("both_left_low", left, 1'b0);
        check_bit("both_right_low", right, 1'b0);
        expect_ev(R_R, t0 + 17);
        expect_ev(R_F, t0 + 21);
        key_left_n = 1'b1; step_to(t0 + 20);
        moveDone = 1'b1;   step_to(t0 + 21);
        moveDone = 1'b0;   step_to(t0 + 22);
        key_right_n = 1'b1;
        step_to(t0 + 55);
        drain("both_keys");

        // Reset while a left request is up; held key re-debounces.
        t0 = cyc;
        expect_ev(L_R, t0 + 7);
        expect_ev(L_F, t0 + 9);
        key_left_n = 1'b0;
        step_to(t0 + 9);
        reset = 1'b1;
        #1;
        check_bit("async_reset_left", left, 1'b0);
        step_to(t0 + 12);
        expect_ev(L_R, t0 + 19);
        expect_ev(L_F, t0 + 23);
        reset = 1'b0;      step_to(t0 + 22);
        moveDone = 1'b1;   step_to(t0 + 23);
        moveDone = 1'b0;
        key_left_n = 1'b1;
        step_to(t0 + 60);
        drain("reset_mid_request");

        // Three-cycle glitch is shorter than the debounce window.
        t0 = cyc;
        key_left_n = 1'b0; step_to(t0 + 3);
        key_left_n = 1'b1; step_to(t0 + 25);
        check_bit("glitch_left_low", left, 1'b0);
        check_bit("glitch_right_low", right, 1'b0);
        drain("glitch");

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
